// File: rtl/i2c_arb_pkg.sv
// ---------------------------------------------------------------------------
// i2c_arb_pkg
// Shared types and constants for the two-requester I2C transmit arbiter.
//   arb_state_t : frame sequencer states
//   NUM_REQ     : number of requesters sharing the I2C master
//   MAX_LEN     : largest data byte count a requester may ask for
//   LEN_W       : width of a length / byte index field
// ---------------------------------------------------------------------------
package i2c_arb_pkg;

    localparam int NUM_REQ = 2;
    localparam int MAX_LEN = 7;
    localparam int LEN_W   = $clog2(MAX_LEN + 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        WAIT  = 3'd2,
        DATA  = 3'd3,
        STOP  = 3'd4,
        DONE  = 3'd5
    } arb_state_t;

    // With two requesters the one-hot grant collapses to the index of bit 1.
    function automatic logic onehot2_to_idx(input logic [NUM_REQ-1:0] oh);
        return oh[1];
    endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// ---------------------------------------------------------------------------
// rr_arbiter2
// Combinational two-way round-robin decision.
//   req  [1:0] : pending requests
//   last       : index of the requester granted most recently
//   gnt  [1:0] : one-hot winner (all zero when nothing is requested)
// On contention the requester that was not granted last wins.
// ---------------------------------------------------------------------------
module rr_arbiter2
    import i2c_arb_pkg::*;
(
    input  logic [NUM_REQ-1:0] req,
    input  logic               last,
    output logic [NUM_REQ-1:0] gnt
);

    always_comb begin
        gnt = '0;
        unique case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = last ? 2'b01 : 2'b10;
            default: gnt = '0;
        endcase
    end

endmodule

// File: rtl/i2c_tx_arbiter.sv
// ---------------------------------------------------------------------------
// i2c_tx_arbiter
// Shares one byte-oriented I2C master between two requesters. A granted
// requester gets a full frame: START+address, req_len data bytes, STOP.
//
// Ports
//   clk, reset_n        clock, asynchronous active-low reset
//   req      [1:0]      frame request per requester (level, held until done)
//   req_addr [1:0][7:0] address byte (7-bit address + R/W) per requester
//   req_len  [1:0][2:0] data byte count per requester, sampled at grant
//   req_data [1:0][7:0] data byte at byte_idx, per requester
//   abort    [1:0]      per-requester abort (level)
//   grant    [1:0]      one-hot owner of the I2C master
//   byte_idx [2:0]      index of the data byte being fetched
//   done     [1:0]      one-cycle frame-complete pulse
//   aborted  [1:0]      one-cycle abort / timeout pulse
//   start, stop, i2c_en I2C master commands
//   tx_data  [7:0]      byte presented to the I2C master
//   ready               I2C master idle
//   tx_done             I2C master byte strobe (monitored only)
//
// Build option: define I2C_ARB_TIMEOUT_EN to add a ready-wait watchdog of
// TIMEOUT_CYCLES clocks; without it every wait on ready is unbounded.
//
// Every output comes straight from a flop, so ready never reaches an
// output combinationally.
// ---------------------------------------------------------------------------
module i2c_tx_arbiter
    import i2c_arb_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic [NUM_REQ-1:0]            req,
    input  logic [NUM_REQ-1:0][7:0]       req_addr,
    input  logic [NUM_REQ-1:0][LEN_W-1:0] req_len,
    input  logic [NUM_REQ-1:0][7:0]       req_data,
    input  logic [NUM_REQ-1:0]            abort,
    output logic [NUM_REQ-1:0]            grant,
    output logic [LEN_W-1:0]              byte_idx,
    output logic [NUM_REQ-1:0]            done,
    output logic [NUM_REQ-1:0]            aborted,
    output logic                          start,
    output logic                          stop,
    output logic                          i2c_en,
    output logic [7:0]                    tx_data,
    input  logic                          ready,
    input  logic                          tx_done
);

    arb_state_t           state_q;
    logic [NUM_REQ-1:0]   grant_q;
    logic                 owner_q;       // index form of grant_q
    logic                 last_q;        // index of the most recent winner
    logic [LEN_W-1:0]     len_q;
    logic [LEN_W-1:0]     byte_idx_q;
    logic [7:0]           tx_data_q;
    logic [NUM_REQ-1:0]   done_q;
    logic [NUM_REQ-1:0]   aborted_q;
    logic                 start_q;
    logic                 stop_q;
    logic                 i2c_en_q;
    logic                 abort_pend_q;  // owner asked to abort; honoured at next WAIT
    logic                 hold_q;        // forces one idle cycle after a frame ends

    logic [NUM_REQ-1:0]   rr_gnt;
    logic                 rr_idx;
    logic                 own_abort;

    rr_arbiter2 u_rr (
        .req  (req),
        .last (last_q),
        .gnt  (rr_gnt)
    );

    assign rr_idx    = onehot2_to_idx(rr_gnt);
    // Only the owner's abort is looked at; the other requester is ignored.
    assign own_abort = abort[owner_q];

`ifdef I2C_ARB_TIMEOUT_EN
    localparam int TMO_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

    logic [TMO_W-1:0] tmo_q;
    logic             waiting;

    // True exactly when the sequencer is parked waiting for the master and
    // will not change state this cycle. WAIT is excluded on purpose.
    always_comb begin
        waiting = 1'b0;
        unique case (state_q)
            START, DATA, STOP: waiting = ready;
            DONE:              waiting = !ready;
            default:           waiting = 1'b0;
        endcase
    end
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            grant_q      <= '0;
            owner_q      <= 1'b0;
            last_q       <= 1'b1;   // makes requester 0 the first winner
            len_q        <= '0;
            byte_idx_q   <= '0;
            tx_data_q    <= '0;
            done_q       <= '0;
            aborted_q    <= '0;
            start_q      <= 1'b0;
            stop_q       <= 1'b0;
            i2c_en_q     <= 1'b0;
            abort_pend_q <= 1'b0;
            hold_q       <= 1'b0;
`ifdef I2C_ARB_TIMEOUT_EN
            tmo_q        <= '0;
`endif
        end else begin
            done_q    <= '0;
            aborted_q <= '0;

            unique case (state_q)
                IDLE: begin
                    if (hold_q) begin
                        hold_q <= 1'b0;
                    end else if (|req) begin
                        grant_q      <= rr_gnt;
                        owner_q      <= rr_idx;
                        last_q       <= rr_idx;
                        tx_data_q    <= req_addr[rr_idx];
                        len_q        <= req_len[rr_idx];
                        byte_idx_q   <= '0;
                        abort_pend_q <= 1'b0;
                        start_q      <= 1'b1;
                        i2c_en_q     <= 1'b1;
                        state_q      <= START;
                    end
                end

                START: begin
                    if (own_abort) abort_pend_q <= 1'b1;
                    // The master accepted the command once it goes busy.
                    if (!ready) begin
                        start_q  <= 1'b0;
                        i2c_en_q <= 1'b0;
                        state_q  <= WAIT;
                    end
                end

                WAIT: begin
                    if (own_abort) abort_pend_q <= 1'b1;
                    if (ready) begin
                        if (abort_pend_q || own_abort) begin
                            stop_q   <= 1'b1;
                            i2c_en_q <= 1'b1;
                            state_q  <= STOP;
                        end else if (byte_idx_q < len_q) begin
                            tx_data_q <= req_data[owner_q];
                            i2c_en_q  <= 1'b1;
                            state_q   <= DATA;
                        end else begin
                            stop_q   <= 1'b1;
                            i2c_en_q <= 1'b1;
                            state_q  <= STOP;
                        end
                    end
                end

                DATA: begin
                    if (own_abort) abort_pend_q <= 1'b1;
                    // Let the byte in flight finish; abort is taken at WAIT.
                    if (!ready) begin
                        i2c_en_q   <= 1'b0;
                        byte_idx_q <= byte_idx_q + 1'b1;
                        state_q    <= WAIT;
                    end
                end

                STOP: begin
                    if (!ready) begin
                        stop_q   <= 1'b0;
                        i2c_en_q <= 1'b0;
                        state_q  <= DONE;
                    end
                end

                DONE: begin
                    if (ready) begin
                        if (abort_pend_q) aborted_q <= grant_q;
                        else              done_q    <= grant_q;
                        abort_pend_q <= 1'b0;
                        grant_q      <= '0;
                        hold_q       <= 1'b1;
                        state_q      <= IDLE;
                    end
                end

                default: begin
                    state_q  <= IDLE;
                    grant_q  <= '0;
                    start_q  <= 1'b0;
                    stop_q   <= 1'b0;
                    i2c_en_q <= 1'b0;
                end
            endcase

`ifdef I2C_ARB_TIMEOUT_EN
            // Placed after the case so a timeout overrides the normal update.
            if (waiting) begin
                if (tmo_q == TMO_LAST) begin
                    aborted_q    <= grant_q;
                    grant_q      <= '0;
                    start_q      <= 1'b0;
                    stop_q       <= 1'b0;
                    i2c_en_q     <= 1'b0;
                    abort_pend_q <= 1'b0;
                    hold_q       <= 1'b1;
                    state_q      <= IDLE;
                    tmo_q        <= '0;
                end else begin
                    tmo_q <= tmo_q + 1'b1;
                end
            end else begin
                tmo_q <= '0;
            end
`endif
        end
    end

    assign grant    = grant_q;
    assign byte_idx = byte_idx_q;
    assign done     = done_q;
    assign aborted  = aborted_q;
    assign start    = start_q;
    assign stop     = stop_q;
    assign i2c_en   = i2c_en_q;
    assign tx_data  = tx_data_q;

    // tx_done is informational only; the timeout limit is unused when the
    // watchdog is compiled out.
    logic unused_ok;
    assign unused_ok = &{1'b0, tx_done, (TIMEOUT_CYCLES > 0)};

endmodule
